// File: rtl/cover_pkg.sv
// Shared definitions for the toggle-cover collectors: global index type,
// design-wide cover point total and a population-count helper.
package cover_pkg;

    localparam int COVER_TOTAL = 11747;
    localparam int COVER_IDX_W = 64;

    typedef logic [COVER_IDX_W-1:0] cover_idx_t;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cover_toggle_collector_if.sv
// Report stream of the toggle-cover collector (valid/ready + global index).
// COVER_COLLECTOR_TIMESTAMP_EN adds the out_stamp field.
interface cover_toggle_collector_if;
    import cover_pkg::*;

    logic       out_valid;
    logic       out_ready;
    cover_idx_t out_index;
`ifdef COVER_COLLECTOR_TIMESTAMP_EN
    logic [31:0] out_stamp;

    modport master (output out_valid, output out_index, output out_stamp, input out_ready);
    modport slave  (input out_valid, input out_index, input out_stamp, output out_ready);
`else
    modport master (output out_valid, output out_index, input out_ready);
    modport slave  (input out_valid, input out_index, output out_ready);
`endif

endinterface

// File: rtl/cover_lsb_encoder.sv
// Combinational lowest-set-bit encoder with an any-set flag.
module cover_lsb_encoder #(
    parameter  int W  = 11,
    localparam int PW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  i_vec,
    output logic [PW-1:0] o_pos,
    output logic          o_any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o_pos = {PW{1'b0}};
        o_any = |i_vec;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_pos = PW'(i);
            end else begin
                o_pos = o_pos;
            end
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// Sticky first-hit collector for one toggle-cover group; streams each new hit
// once as a global index. COVER_COLLECTOR_TIMESTAMP_EN adds a cycle stamp.
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter  int         W           = 11,
    parameter  cover_idx_t COVER_INDEX = 64'd0,
    parameter  int         COVER_TOTAL = cover_pkg::COVER_TOTAL,
    localparam int         CW          = $clog2(W + 1),
    localparam int         PW          = (W > 1) ? $clog2(W) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [W-1:0]                    valid,
    input  logic                            clear,
    cover_toggle_collector_if.master        cov_out,
    output logic [CW-1:0]                   hit_count,
    output logic                            all_hit
);

    if ((W < 1) || (W > 64)) begin : g_bad_width
        $error("cover_toggle_collector: W must be within 1..64");
    end
    if ((COVER_INDEX + 64'(W)) > 64'(COVER_TOTAL)) begin : g_bad_index
        $error("cover_toggle_collector: COVER_INDEX+W exceeds COVER_TOTAL");
    end

    logic [W-1:0]  r_seen;
    logic [W-1:0]  r_pending;
    logic [CW-1:0] r_hit_count;
    logic          r_all_hit;
    logic          r_out_valid;
    cover_idx_t    r_out_index;

    logic [W-1:0]  w_new;
    logic [W-1:0]  w_seen_nxt;
    logic [W-1:0]  w_pend_nxt;
    logic [W-1:0]  w_take;
    logic [6:0]    w_pop;
    logic [PW-1:0] w_pos;
    logic          w_any;
    logic          w_load;

    cover_lsb_encoder #(.W(W)) u_lsb (
        .i_vec (r_pending),
        .o_pos (w_pos),
        .o_any (w_any)
    );

    // Hit tracking and output-stage load decision for this edge.
    always_comb begin
        w_new      = valid & ~r_seen;
        w_seen_nxt = r_seen | valid;
        w_pop      = popcount64(64'(w_new));
        w_load     = ~r_out_valid | cov_out.out_ready;
        if (w_load && w_any) begin
            w_take = W'(1'b1) << w_pos;
        end else begin
            w_take = {W{1'b0}};
        end
        w_pend_nxt = (r_pending & ~w_take) | w_new;
    end

    // Collector state and one-entry output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_seen      <= {W{1'b0}};
            r_pending   <= {W{1'b0}};
            r_hit_count <= {CW{1'b0}};
            r_all_hit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_index <= 64'd0;
        end else if (clear) begin
            r_seen      <= {W{1'b0}};
            r_pending   <= {W{1'b0}};
            r_hit_count <= {CW{1'b0}};
            r_all_hit   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_seen      <= w_seen_nxt;
            r_pending   <= w_pend_nxt;
            r_hit_count <= r_hit_count + w_pop[CW-1:0];
            r_all_hit   <= &w_seen_nxt;
            if (w_load) begin
                r_out_valid <= w_any;
                if (w_any) begin
                    r_out_index <= COVER_INDEX + cover_idx_t'(w_pos);
                end
            end
        end
    end

`ifdef COVER_COLLECTOR_TIMESTAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_stamp;

    // Free-running cycle counter; the stamp follows out_index loads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle <= 32'd0;
            r_stamp <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (!clear && w_load && w_any) begin
                r_stamp <= r_cycle;
            end
        end
    end

    assign cov_out.out_stamp = r_stamp;
`endif

    assign cov_out.out_valid = r_out_valid;
    assign cov_out.out_index = r_out_index;
    assign hit_count         = r_hit_count;
    assign all_hit           = r_all_hit;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Randomized + directed bench for cover_toggle_collector against a set-based model.
module tb_cover_toggle_collector;

    localparam int W = 11;
    localparam longint unsigned CI = 100;

    logic         clock = 1'b0;
    logic         reset;
    logic         clear;
    logic [W-1:0] valid;
    logic [3:0]   hit_count;
    logic         all_hit;

    cover_toggle_collector_if bus();

    cover_toggle_collector #(.W(W), .COVER_INDEX(64'd100)) dut (
        .clock     (clock),
        .reset     (reset),
        .valid     (valid),
        .clear     (clear),
        .cov_out   (bus),
        .hit_count (hit_count),
        .all_hit   (all_hit)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model: sets of seen / pending points plus the visible output register
    bit              m_seen[W];
    bit              m_pend[W];
    bit              m_ov;
    longint unsigned m_idx;
    int              m_cnt;
    bit              m_all;
    int unsigned     m_cyc;
    int unsigned     m_stamp;

    longint unsigned acc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_seen[i]) begin
            m_seen[i] = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_ov = 1'b0; m_idx = 0; m_cnt = 0; m_all = 1'b0; m_cyc = 0; m_stamp = 0;
    endtask

    task automatic model_step();
        int p;
        bit load;
        if (clear) begin
            foreach (m_seen[i]) begin
                m_seen[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
            m_cnt = 0; m_ov = 1'b0; m_all = 1'b0;
        end else begin
            load = !m_ov || bus.out_ready;
            p = -1;
            for (int i = 0; i < W; i++) if (m_pend[i] && p < 0) p = i;
            if (load) begin
                if (p >= 0) begin
                    m_ov = 1'b1; m_idx = CI + longint'(p); m_pend[p] = 1'b0; m_stamp = m_cyc;
                end else begin
                    m_ov = 1'b0;
                end
            end
            for (int i = 0; i < W; i++) begin
                if (valid[i] && !m_seen[i]) begin
                    m_seen[i] = 1'b1; m_pend[i] = 1'b1; m_cnt++;
                end
            end
            m_all = (m_cnt == W);
        end
        m_cyc++;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(posedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) acc.push_back(bus.out_index);
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("out_valid", 64'(bus.out_valid), 64'(m_ov));
            check("out_index", bus.out_index, 64'(m_idx));
            check("hit_count", 64'(hit_count), 64'(m_cnt));
            check("all_hit", 64'(all_hit), 64'(m_all));
`ifdef COVER_COLLECTOR_TIMESTAMP_EN
            check("out_stamp", 64'(bus.out_stamp), 64'(m_stamp));
`endif
        end
    end

    task automatic cyc(input logic [W-1:0] v, input logic c);
        @(negedge clock);
        valid = v;
        clear = c;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(11'h000, 1'b0);
    endtask

    task automatic check_acc(input string name, input longint unsigned e0, input longint unsigned e1,
                             input longint unsigned e2, input int n);
        longint unsigned e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        check({name, "_count"}, 64'(acc.size()), 64'(n));
        for (int i = 0; i < n && i < acc.size(); i++) check({name, "_idx"}, 64'(acc[i]), 64'(e[i]));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; valid = 11'h000; bus.out_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_index", bus.out_index, 64'd0);
        check("rst_hit_count", 64'(hit_count), 64'd0);
        check("rst_all_hit", 64'(all_hit), 64'd0);
        chk_en = 1'b1;

        // single hit: visible two edges later, one report
        cyc(11'h001, 1'b0);
        cyc(11'h000, 1'b0);
        check("lat_e1_valid", 64'(bus.out_valid), 64'd0);
        cyc(11'h000, 1'b0);
        check("lat_e2_valid", 64'(bus.out_valid), 64'd1);
        check("lat_e2_index", bus.out_index, 64'd100);
        idle(4);
        check_acc("single", 100, 0, 0, 1);
        check("single_hits", 64'(hit_count), 64'd1);

        // repeated toggles report once
        cyc(11'h000, 1'b1); acc.delete();
        repeat (10) cyc(11'h001, 1'b0);
        idle(3);
        check_acc("repeat", 100, 0, 0, 1);
        check("repeat_hits", 64'(hit_count), 64'd1);

        // several new bits: lowest first
        cyc(11'h000, 1'b1); acc.delete();
        cyc(11'h421, 1'b0);
        idle(5);
        check_acc("multi", 100, 105, 110, 3);
        check("multi_hits", 64'(hit_count), 64'd3);

        // backpressure holds the output
        cyc(11'h000, 1'b1); acc.delete();
        bus.out_ready = 1'b0;
        cyc(11'h006, 1'b0);
        idle(6);
        check("bp_valid", 64'(bus.out_valid), 64'd1);
        check("bp_index", bus.out_index, 64'd101);
        check_acc("bp_none", 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        idle(4);
        check_acc("bp", 101, 102, 0, 2);

        // full coverage, then clear and re-hit
        cyc(11'h7FF, 1'b0);
        idle(14);
        check("full_all_hit", 64'(all_hit), 64'd1);
        check("full_hits", 64'(hit_count), 64'd11);
        cyc(11'h000, 1'b1);
        cyc(11'h000, 1'b0);
        check("clr_hits", 64'(hit_count), 64'd0);
        check("clr_all_hit", 64'(all_hit), 64'd0);
        check("clr_valid", 64'(bus.out_valid), 64'd0);
        acc.delete();
        cyc(11'h008, 1'b0);
        idle(4);
        check_acc("rehit", 103, 0, 0, 1);

        // random traffic
        repeat (400) begin
            @(negedge clock);
            valid = W'($urandom & $urandom & $urandom);
            clear = ($urandom_range(0, 39) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end

        // asynchronous reset with work in flight
        bus.out_ready = 1'b0;
        cyc(11'h000, 1'b1);
        cyc(11'h7FF, 1'b0);
        cyc(11'h000, 1'b0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_index", bus.out_index, 64'd0);
        check("arst_hits", 64'(hit_count), 64'd0);
        check("arst_all_hit", 64'(all_hit), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        acc.delete();
        bus.out_ready = 1'b1;
        idle(10);
        check_acc("arst_residual", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cover_toggle_collector.md
Name: cover_toggle_collector

Overview:
- Synthesizable consumer for toggle-cover hit vectors, used on FPGA and formal builds where the DPI-based cover sink is unavailable.
- Each cycle it samples a W-bit `valid` vector and records first hits in a sticky bitmap.
- Each newly-hit point is streamed out once, as a global cover index, over a valid/ready interface.
- One instance sits beside each toggle-cover emitter group. Outputs are drained by the coverage uplink arbiter.

Parameters:
- W, 11, number of cover points in this group (1..64).
- COVER_INDEX, 0, global index of bit 0; no default override is allowed at integration and it must be set explicitly.
- COVER_TOTAL, 11747, total cover points in the design; used only for an elaboration check that COVER_INDEX+W <= COVER_TOTAL.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- valid  in  W  per-point hit strobes, sampled every rising edge.
- clear  in  1  synchronous one-cycle pulse that forgets all hits.
- out_valid  out  1  out_index holds an unreported hit.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- out_index  out  64  global cover index (COVER_INDEX + bit position).
- hit_count  out  $clog2(W+1)  number of distinct points hit since reset/clear.
- all_hit  out  1  every point in the group has been hit.

Behaviour:
- Reset (async, active-high): seen, pending, out_valid, out_index, hit_count and all_hit are all 0.
- Per edge, when clear=0:
  - new = valid & ~seen
  - seen |= valid
  - pending |= new
  - hit_count += popcount(new), saturating impossible by construction.
- A point already in seen never re-enters pending. Repeated toggles produce exactly one report.
- Output register (one-entry stage):
  - Load condition: out_valid==0, or the handshake fires this cycle.
  - On load, if pending != 0: take the lowest set bit p, set out_index=COVER_INDEX+p, set out_valid=1, clear pending[p].
  - On load, if pending == 0: out_valid=0.
  - While out_valid=1 and out_ready=0: out_index and out_valid hold stable; no change allowed.
- Latency: a first hit sampled at edge E gives out_valid=1 after edge E+1 if the output stage is free.
- Throughput: one report per cycle under continuous out_ready.
- Simultaneous events:
  - A bit asserted in valid in the same cycle it is loaded into the output is not re-added; seen is already set.
  - Several new bits in one cycle are reported lowest-first on consecutive accepts.
  - Clearing pending[p] on load and setting new bits in the same edge both take effect.
- clear=1:
  - seen, pending, hit_count and out_valid go to 0 at the edge.
  - valid that same cycle is ignored.
  - An unaccepted out_index is dropped.
- all_hit is registered and equals (seen == all ones), updated the same edge as seen.
- 64-bit index arithmetic: zero-extend p and add COVER_INDEX; no wrap.

Optional Feature:
- Macro COVER_COLLECTOR_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter, reset to 0 and wrapping at 2^32. clear does not reset it.
  - Adds port out_stamp (out, 32), loaded with the counter value in the same edge as out_index and held with it.
- Undefined: no counter and no out_stamp port.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package cover_pkg:
  - COVER_TOTAL constant
  - COVER_IDX_W=64
  - typedef cover_idx_t (logic [63:0])
- Sub-module cover_lsb_encoder (parameter W): combinational; outputs lowest-set-bit position and an any-set flag.
- The collector holds all state.

Test Plan (W=11, COVER_INDEX=100, out_ready=1 unless stated):
- valid=11'h001 for one cycle -> out_valid after 2 edges, out_index=100, hit_count=1, exactly one report.
- valid=11'h001 repeatedly for 10 cycles -> exactly one report (100); hit_count stays 1.
- valid=11'h421 (bits 0,5,10) in one cycle -> reports 100, 105, 110 on consecutive cycles; hit_count=3.
- out_ready=0, valid=11'h006 -> out_index=101 held stable for 5 cycles. Then raise out_ready -> 101, then 102.
- Drive all 11 bits -> all_hit=1, hit_count=11. Pulse clear -> hit_count=0, all_hit=0, out_valid=0. Re-hit bit 3 -> reports 103 again.
- Assert reset mid-stream with pending bits -> all outputs 0 immediately, no residual reports after release.
- With COVER_COLLECTOR_TIMESTAMP_EN: hit at cycle 7 -> out_stamp=8.
